// File: rtl/q_hs_source.sv
// Clocked four-phase (return-to-zero) bundled-data source with an input FIFO.
// Optional request timeout is enabled by defining Q_HS_SOURCE_TIMEOUT_EN.
module q_hs_source #(
    parameter int WIDTH        = 8,
    parameter int DEPTH        = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int SETUP_CYCLES = 1,
    parameter int CNT_W        = 16
`ifdef Q_HS_SOURCE_TIMEOUT_EN
    , parameter int TIMEOUT    = 255
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_in,
    output logic [WIDTH-1:0] data_out,
    output logic             req_out,
    input  logic             ack_in,
    output logic             busy,
    output logic [CNT_W-1:0] tx_count
`ifdef Q_HS_SOURCE_TIMEOUT_EN
    , output logic           err_timeout
`endif
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FCNT_W = PTR_W + 1;
    localparam int SC_W   = (SETUP_CYCLES > 1) ? $clog2(SETUP_CYCLES + 1) : 1;
`ifdef Q_HS_SOURCE_TIMEOUT_EN
    localparam int TO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`endif

    typedef enum logic [2:0] {IDLE, SETUP, REQ_HI, REQ_LO, DRAIN} state_t;

    // ack synchroniser
    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   ack_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], ack_in};
        end
    end

    assign ack_s = sync_reg[SYNC_STAGES-1];

    // input FIFO
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [FCNT_W-1:0] count_reg;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              run_reg;

    assign full     = (count_reg == FCNT_W'(DEPTH));
    assign empty    = (count_reg == '0);
    assign ready_in = run_reg && !full;
    assign push     = valid_in && ready_in;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            run_reg    <= 1'b0;
        end else begin
            run_reg <= 1'b1;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + FCNT_W'(1);
                2'b01:   count_reg <= count_reg - FCNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    // handshake FSM
    state_t            state_reg, state_next;
    logic [SC_W-1:0]   setup_reg, setup_next;
    logic              req_reg, req_next;
    logic [WIDTH-1:0]  data_reg, data_next;
    logic [CNT_W-1:0]  tx_reg, tx_next;
`ifdef Q_HS_SOURCE_TIMEOUT_EN
    logic [TO_W-1:0]   to_reg, to_next;
    logic              err_reg, err_next;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            setup_reg <= '0;
            req_reg   <= 1'b0;
            data_reg  <= '0;
            tx_reg    <= '0;
`ifdef Q_HS_SOURCE_TIMEOUT_EN
            to_reg    <= '0;
            err_reg   <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            setup_reg <= setup_next;
            req_reg   <= req_next;
            data_reg  <= data_next;
            tx_reg    <= tx_next;
`ifdef Q_HS_SOURCE_TIMEOUT_EN
            to_reg    <= to_next;
            err_reg   <= err_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        setup_next = setup_reg;
        req_next   = req_reg;
        data_next  = data_reg;
        tx_next    = tx_reg;
        pop        = 1'b0;
`ifdef Q_HS_SOURCE_TIMEOUT_EN
        to_next    = to_reg;
        err_next   = err_reg;
`endif
        case (state_reg)
            IDLE: begin
                // a stale ack must be seen low before any new word is offered
                if (ack_s) begin
                    state_next = DRAIN;
                end else if (!empty) begin
                    pop        = 1'b1;
                    data_next  = mem[rd_ptr_reg];
                    setup_next = SC_W'(SETUP_CYCLES);
                    state_next = SETUP;
                end
            end
            SETUP: begin
                setup_next = setup_reg - SC_W'(1);
                if (setup_reg == SC_W'(1)) begin
                    req_next   = 1'b1;
                    state_next = REQ_HI;
`ifdef Q_HS_SOURCE_TIMEOUT_EN
                    to_next    = '0;
`endif
                end
            end
            REQ_HI: begin
                if (ack_s) begin
                    req_next   = 1'b0;
                    state_next = REQ_LO;
`ifdef Q_HS_SOURCE_TIMEOUT_EN
                    to_next    = '0;
                end else if (to_reg == TO_W'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    req_next   = 1'b0;
                    state_next = DRAIN;
                end else begin
                    to_next    = to_reg + TO_W'(1);
`endif
                end
            end
            REQ_LO: begin
                if (!ack_s) begin
                    tx_next    = tx_reg + CNT_W'(1);
                    state_next = IDLE;
`ifdef Q_HS_SOURCE_TIMEOUT_EN
                end else if (to_reg == TO_W'(TIMEOUT - 1)) begin
                    err_next   = 1'b1;
                    req_next   = 1'b0;
                    state_next = DRAIN;
                end else begin
                    to_next    = to_reg + TO_W'(1);
`endif
                end
            end
            DRAIN: begin
                req_next = 1'b0;
                if (!ack_s) begin
                    state_next = IDLE;
                end
            end
            default: begin
                req_next   = 1'b0;
                state_next = IDLE;
            end
        endcase
    end

    assign data_out = data_reg;
    assign req_out  = req_reg;
    assign tx_count = tx_reg;
    assign busy     = !empty || (state_reg != IDLE);
`ifdef Q_HS_SOURCE_TIMEOUT_EN
    assign err_timeout = err_reg;
`endif

endmodule

// File: tb/tb_q_hs_source.sv
// Self-checking bench for q_hs_source: an ack echo agent drives the pipeline side
// and a scoreboard of pushed words is checked against each request issued.
module tb_q_hs_source;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  data_in = '0;
    logic        valid_in = 1'b0;
    logic        ack_in;
    logic        ready_in, req_out, busy;
    logic [7:0]  data_out;
    logic [15:0] tx_count;
    logic        w_ready, w_req, w_busy;
    logic [7:0]  w_data;
    logic [3:0]  w_tx;
`ifdef Q_HS_SOURCE_TIMEOUT_EN
    logic        err_timeout, w_err;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

`ifdef Q_HS_SOURCE_TIMEOUT_EN
    q_hs_source #(.TIMEOUT(8)) dut (
`else
    q_hs_source dut (
`endif
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_in(ready_in), .data_out(data_out), .req_out(req_out),
        .ack_in(ack_in), .busy(busy), .tx_count(tx_count)
`ifdef Q_HS_SOURCE_TIMEOUT_EN
        , .err_timeout(err_timeout)
`endif
    );

    // narrow-counter copy sharing all inputs, used to observe tx_count wrap
`ifdef Q_HS_SOURCE_TIMEOUT_EN
    q_hs_source #(.CNT_W(4), .TIMEOUT(8)) u_wrap (
`else
    q_hs_source #(.CNT_W(4)) u_wrap (
`endif
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .ready_in(w_ready), .data_out(w_data), .req_out(w_req),
        .ack_in(ack_in), .busy(w_busy), .tx_count(w_tx)
`ifdef Q_HS_SOURCE_TIMEOUT_EN
        , .err_timeout(w_err)
`endif
    );

    // pipeline-side ack agent
    logic echo_en = 1'b0;
    logic echo_rand = 1'b0;
    int   echo_delay = 0;
    logic ack_force_val = 1'b0;

    initial begin
        ack_in = 1'b0;
        forever begin
            @(negedge clk);
            if (!echo_en) begin
                ack_in = ack_force_val;
            end else if (ack_in !== req_out) begin
                int d;
                d = echo_rand ? int'($urandom_range(0, 10)) : echo_delay;
                repeat (d) @(negedge clk);
                if (echo_en) ack_in = req_out;
            end
        end
    end

    // scoreboard of accepted words, in push order
    logic [7:0] sent_q[$];
    int         rises = 0;
    logic       prev_req = 1'b0;
    logic [7:0] prev_data = '0;
    logic [15:0] prev_tx = '0;
    logic       in_hs = 1'b0;
    logic       hs_bad = 1'b0;
    logic [7:0] hs_data = '0;

    always @(posedge clk) begin
        if (rst) in_hs = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst && req_out && !prev_req) begin
            logic [7:0] exp_w;
            rises++;
            checks++;
            if (sent_q.size() == 0) begin
                failures++;
                $display("FAIL req_word: request with data %h but no word outstanding", data_out);
            end else begin
                exp_w = sent_q.pop_front();
                if (data_out !== exp_w) begin
                    failures++;
                    $display("FAIL req_word: data_out=%h expected %h", data_out, exp_w);
                end
            end
            checks++;
            if (data_out !== prev_data) begin
                failures++;
                $display("FAIL setup: data_out=%h at req rise, was %h one clock before", data_out, prev_data);
            end
            in_hs   = 1'b1;
            hs_bad  = 1'b0;
            hs_data = data_out;
        end else if (in_hs) begin
            if (data_out !== hs_data) hs_bad = 1'b1;
            if (tx_count !== prev_tx) begin
                checks++;
                if (hs_bad) begin
                    failures++;
                    $display("FAIL stable: data_out=%h changed during handshake of %h", data_out, hs_data);
                end
                $display("handshake done word=%h tx_count=%0d", hs_data, tx_count);
                in_hs = 1'b0;
            end else if (!busy) begin
                in_hs = 1'b0;
            end
        end
        prev_req  = req_out;
        prev_data = data_out;
        prev_tx   = tx_count;
    end

    task automatic push(input logic [7:0] w);
        int t = 0;
        data_in  = w;
        valid_in = 1'b1;
        while (!ready_in && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) begin
            checks++;
            failures++;
            $display("FAIL push_wait: ready_in=%b never returned 1 for word %h", ready_in, w);
            valid_in = 1'b0;
        end else begin
            @(negedge clk);
            valid_in = 1'b0;
            sent_q.push_back(w);
        end
    endtask

    task automatic wait_idle(input int budget);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while ((busy || req_out || ack_in) && t < budget);
        if (t >= budget) begin
            checks++;
            failures++;
            $display("FAIL idle_wait: busy=%b req_out=%b ack_in=%b after %0d clocks, required idle", busy, req_out, ack_in, t);
        end
    endtask

    task automatic wait_req(input logic val, input int budget);
        int t = 0;
        while (req_out !== val && t < budget) begin
            @(negedge clk);
            t++;
        end
        if (t >= budget) begin
            checks++;
            failures++;
            $display("FAIL req_wait: req_out=%b, required %b within %0d clocks", req_out, val, budget);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        valid_in = 1'b0;
        repeat (2) @(negedge clk);
        sent_q.delete();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        echo_en = 1'b0;
        ack_force_val = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks += 6;
        if (req_out !== 1'b0) begin failures++; $display("FAIL rst_req: req_out=%b expected 0", req_out); end
        if (data_out !== 8'h00) begin failures++; $display("FAIL rst_data: data_out=%h expected 00", data_out); end
        if (ready_in !== 1'b0) begin failures++; $display("FAIL rst_ready: ready_in=%b expected 0", ready_in); end
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: busy=%b expected 0", busy); end
        if (tx_count !== 16'd0) begin failures++; $display("FAIL rst_tx: tx_count=%0d expected 0", tx_count); end
        if (w_tx !== 4'd0) begin failures++; $display("FAIL rst_wtx: tx_count=%0d expected 0", w_tx); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ready_in !== 1'b1) begin failures++; $display("FAIL rst_release_ready: ready_in=%b expected 1", ready_in); end
        $display("test_reset done");
    endtask

    task automatic test_single();
        int r0;
        do_reset();
        echo_en = 1'b1;
        echo_rand = 1'b0;
        echo_delay = 3;
        r0 = rises;
        push(8'hA5);
        wait_idle(100);
        repeat (3) @(negedge clk);
        checks += 3;
        if (rises - r0 !== 1) begin failures++; $display("FAIL single_pulses: %0d req pulses, expected 1", rises - r0); end
        if (tx_count !== 16'd1) begin failures++; $display("FAIL single_tx: tx_count=%0d expected 1", tx_count); end
        if (busy !== 1'b0) begin failures++; $display("FAIL single_busy: busy=%b expected 0", busy); end
        $display("test_single done tx_count=%0d", tx_count);
    endtask

    task automatic test_full_fifo();
        logic [15:0] base;
        wait_idle(200);
        base = tx_count;
        echo_en = 1'b0;
        ack_force_val = 1'b0;
        for (int i = 0; i < 5; i++) push(8'($urandom));
        checks++;
        if (ready_in !== 1'b0) begin failures++; $display("FAIL full_ready: ready_in=%b after 5 pushes, expected 0", ready_in); end
        repeat (2) @(negedge clk);
        checks++;
        if (req_out !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL full_first_req: req_out=%b busy=%b, expected 1 1", req_out, busy);
        end
        echo_en = 1'b1;
        echo_delay = 2;
        wait_idle(400);
        checks++;
        if (tx_count !== base + 16'd5) begin failures++; $display("FAIL full_tx: tx_count=%0d expected %0d", tx_count, base + 16'd5); end
        $display("test_full_fifo done tx_count=%0d", tx_count);
    endtask

    task automatic test_random_stream();
        logic [15:0] base;
        wait_idle(200);
        base = tx_count;
        echo_en = 1'b1;
        echo_rand = 1'b1;
        for (int i = 0; i < 100; i++) begin
            push(8'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        wait_idle(5000);
        echo_rand = 1'b0;
        checks += 2;
        if (tx_count !== base + 16'd100) begin failures++; $display("FAIL stream_tx: tx_count=%0d expected %0d", tx_count, base + 16'd100); end
        if (sent_q.size() != 0) begin failures++; $display("FAIL stream_left: %0d words never requested, expected 0", sent_q.size()); end
        $display("test_random_stream done tx_count=%0d", tx_count);
    endtask

    task automatic test_reset_req_lo();
        int k = 0;
        logic early = 1'b0;
        wait_idle(200);
        echo_en = 1'b0;
        ack_force_val = 1'b0;
        push(8'h3C);
        wait_req(1'b1, 30);
        ack_force_val = 1'b1;
        wait_req(1'b0, 30);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        sent_q.delete();
        @(negedge clk);
        rst = 1'b0;
        checks += 3;
        if (req_out !== 1'b0) begin failures++; $display("FAIL midrst_req: req_out=%b expected 0", req_out); end
        if (tx_count !== 16'd0) begin failures++; $display("FAIL midrst_tx: tx_count=%0d expected 0", tx_count); end
        if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy: busy=%b expected 0", busy); end
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL drain_busy: busy=%b with ack high, expected 1", busy); end
        push(8'h7E);
        repeat (6) begin
            @(negedge clk);
            if (req_out !== 1'b0) early = 1'b1;
        end
        checks++;
        if (early) begin failures++; $display("FAIL drain_hold: req_out=1 while ack high, expected 0"); end
        ack_force_val = 1'b0;
        while (req_out !== 1'b1 && k < 30) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k <= 2 || k >= 30) begin failures++; $display("FAIL drain_release: req rose %0d clocks after ack low, expected 3..29", k); end
        echo_en = 1'b1;
        echo_delay = 1;
        wait_idle(100);
        checks++;
        if (tx_count !== 16'd1) begin failures++; $display("FAIL midrst_after_tx: tx_count=%0d expected 1", tx_count); end
        $display("test_reset_req_lo done release_clocks=%0d", k);
    endtask

    task automatic test_wrap();
        do_reset();
        echo_en = 1'b1;
        echo_delay = 0;
        for (int i = 1; i <= 17; i++) begin
            push(8'(i * 7));
            wait_idle(200);
            checks += 2;
            if (w_tx !== 4'(i)) begin failures++; $display("FAIL wrap_tx: narrow tx_count=%0d expected %0d", w_tx, i % 16); end
            if (tx_count !== 16'(i)) begin failures++; $display("FAIL wrap_wide_tx: tx_count=%0d expected %0d", tx_count, i); end
        end
        $display("test_wrap done narrow tx_count=%0d", w_tx);
    endtask

`ifdef Q_HS_SOURCE_TIMEOUT_EN
    task automatic test_timeout();
        logic [15:0] base;
        wait_idle(200);
        base = tx_count;
        echo_en = 1'b0;
        ack_force_val = 1'b0;
        push(8'h99);
        wait_req(1'b1, 30);
        repeat (7) @(negedge clk);
        checks++;
        if (err_timeout !== 1'b0) begin failures++; $display("FAIL to_early: err_timeout=%b at 7 clocks, expected 0", err_timeout); end
        @(negedge clk);
        checks += 3;
        if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_flag: err_timeout=%b at 8 clocks, expected 1", err_timeout); end
        if (req_out !== 1'b0) begin failures++; $display("FAIL to_req: req_out=%b expected 0", req_out); end
        if (tx_count !== base) begin failures++; $display("FAIL to_tx: tx_count=%0d expected %0d", tx_count, base); end
        echo_en = 1'b1;
        echo_delay = 1;
        push(8'h42);
        wait_idle(100);
        checks += 2;
        if (tx_count !== base + 16'd1) begin failures++; $display("FAIL to_next_tx: tx_count=%0d expected %0d", tx_count, base + 16'd1); end
        if (err_timeout !== 1'b1) begin failures++; $display("FAIL to_sticky: err_timeout=%b expected 1", err_timeout); end
        $display("test_timeout done");
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_full_fifo();
        test_random_stream();
        test_reset_req_lo();
        test_wrap();
`ifdef Q_HS_SOURCE_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
